// File: rtl/mul_cic_decimator.sv
// mul_cic_decimator
//   Six-stage Hogenauer CIC decimator (R = 128, differential delay 1) that
//   turns a 2-bit signed sigma-delta bitstream into wide signed words.
//   The input sample rate is derived internally by dividing the system clock
//   by SAMPLE_DIV. There is therefore no sample-enable input.
//
// Ports
//   clk   system clock; all logic runs on the rising edge
//   rst   synchronous reset, active-high; clears every register
//   Xin   signed input sample (IN_W bits), captured only on sample strobes
//   Yout  signed decimated output (OUT_W bits), registered and held
//   rdy   one-clock pulse in the cycle where Yout carries a new value
//
// Handshake: rdy is a pure strobe with no back-pressure. Yout is valid in
// the cycle rdy is high and holds that value until the next rdy pulse.
module mul_cic_decimator #(
  parameter int IN_W       = 2,
  parameter int OUT_W      = 44,
  parameter int N          = 6,
  parameter int R          = 128,
  parameter int SAMPLE_DIV = 98
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  Xin,
  output logic signed [OUT_W-1:0] Yout,
  output logic                    rdy
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int DEC_W = (R > 1) ? $clog2(R) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(R - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [DEC_W-1:0] dec_cnt;
  logic             strobe;
  logic             decim;

  logic [OUT_W-1:0] integ   [N];
  logic [OUT_W-1:0] dly     [N];
  logic [OUT_W-1:0] comb_in [N];
  logic [OUT_W-1:0] comb_out;
  logic [OUT_W-1:0] x_ext;

  assign strobe = (div_cnt == DIV_LAST);
  assign decim  = strobe && (dec_cnt == DEC_LAST);
  assign x_ext  = {{(OUT_W-IN_W){Xin[IN_W-1]}}, Xin};

  // Input-rate divider: free-running 0..SAMPLE_DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (strobe) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Decimation phase: counts strobes 0..R-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_cnt <= '0;
    end else if (strobe) begin
      if (dec_cnt == DEC_LAST) begin
        dec_cnt <= '0;
      end else begin
        dec_cnt <= dec_cnt + DEC_W'(1);
      end
    end
  end

  // Pipelined integrators. Each stage adds the previous stage's old
  // register value. Sums wrap modulo 2^OUT_W on purpose: the combs cancel
  // the wrap as long as the true output fits in OUT_W bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        integ[k] <= '0;
      end
    end else if (strobe) begin
      integ[0] <= integ[0] + x_ext;
      for (int k = 1; k < N; k++) begin
        integ[k] <= integ[k] + integ[k-1];
      end
    end
  end

  // Comb chain evaluated combinationally at the low rate. Its input is the
  // last integrator's value before this strobe's update. comb_in[k] is the
  // input to comb stage k, which is also what its delay register stores.
  always_comb begin
    logic [OUT_W-1:0] acc;
    acc = integ[N-1];
    for (int k = 0; k < N; k++) begin
      comb_in[k] = acc;
      acc        = acc - dly[k];
    end
    comb_out = acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        dly[k] <= '0;
      end
    end else if (decim) begin
      for (int k = 0; k < N; k++) begin
        dly[k] <= comb_in[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Yout <= '0;
      rdy  <= 1'b0;
    end else begin
      rdy <= decim;
      if (decim) begin
        Yout <= comb_out;
      end
    end
  end

endmodule

// File: tb/tb_mul_cic_decimator.sv
// Testbench for mul_cic_decimator.
//   The DUT runs with SAMPLE_DIV = 4 so that many output words fit in a
//   short run. The reference is an FIR form of the filter: the impulse
//   response of six cascaded length-128 boxcars, plus the six-sample
//   integrator pipeline delay, applied to the recorded input history.
module tb_mul_cic_decimator;

  localparam int SD  = 4;
  localparam int RR  = 128;
  localparam int NN  = 6;
  localparam int HL  = NN * (RR - 1) + 1;
  localparam int PER = SD * RR;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic signed [1:0]   Xin = 2'sb00;
  logic signed [43:0]  Yout;
  logic                rdy;

  int                  checks = 0;
  int                  errors = 0;
  int                  cyc    = 0;
  longint              h [HL];
  int                  xh [$];
  logic signed [43:0]  y_exp  = '0;
  real                 sd_acc = 0.0;
  int                  sd_y   = 1;

  mul_cic_decimator #(
    .IN_W(2), .OUT_W(44), .N(NN), .R(RR), .SAMPLE_DIV(SD)
  ) dut (
    .clk(clk), .rst(rst), .Xin(Xin), .Yout(Yout), .rdy(rdy)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Expected output m: y = sum_j h[j] * x[t-6-j], t = m*R + R-1.
  function automatic longint model(input int m);
    longint acc = 0;
    int     t   = m * RR + RR - 1;
    for (int j = 0; j < HL; j++) begin
      int idx = t - NN - j;
      if (idx >= 0 && idx < xh.size()) acc += h[j] * longint'(xh[idx]);
    end
    return acc;
  endfunction

  // One clock; checks rdy timing and that Yout is either new or held.
  task automatic tick();
    longint m;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc % PER == 0) begin
      m     = model(cyc / PER - 1);
      y_exp = m[43:0];
      chk("rdy_pulse", rdy, 1);
    end else begin
      chk("rdy_idle", rdy, 0);
    end
    chk("yout", Yout, y_exp);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("rst_yout", Yout, 0);
      chk("rst_rdy", rdy, 0);
    end
    rst    = 1'b0;
    cyc    = 0;
    y_exp  = '0;
    sd_acc = 0.0;
    sd_y   = 1;
    xh.delete();
  endtask

  // mode 0: constant cval; 1: alternating +1/-1; 2: sigma-delta sine.
  // glitch drives -2 for the first clock of each sample period to show that
  // only the strobe cycle matters. settle enables steady-state checks once
  // a full impulse response lies inside this segment.
  task automatic run_seg(input string tag, input int mode, input int cval,
                         input int n_smp, input bit glitch, input bit settle,
                         input longint settle_val);
    int     s0 = xh.size();
    int     v, t;
    int     lim;
    longint yv;
    real    u;
    logic [31:0] vb;
    for (int i = 0; i < n_smp; i++) begin
      t = xh.size();
      case (mode)
        0:       v = cval;
        1:       v = (t % 2 == 0) ? 1 : -1;
        default: begin
          u      = 0.5 * $sin(2.0 * 3.14159265358979 * 1000.0 * t * 1954.0e-9);
          sd_acc = sd_acc + u - real'(sd_y);
          sd_y   = (sd_acc >= 0.0) ? 1 : -1;
          v      = sd_y;
        end
      endcase
      vb = v;
      xh.push_back(v);
      if (glitch) begin
        Xin = 2'sb10;
        tick();
        Xin = vb[1:0];
        repeat (SD - 1) tick();
      end else begin
        Xin = vb[1:0];
        repeat (SD) tick();
      end
      if (settle && (t % RR == RR - 1) && (t - s0 >= 8 * RR - 1)) begin
        if (mode == 1) begin
          yv  = Yout;
          lim = (yv <= 64'sd68719476736 && yv >= -64'sd68719476736) ? 1 : 0;
          chk({tag, "_bound"}, lim, 1);
        end else begin
          chk({tag, "_settled"}, Yout, settle_val);
        end
      end
    end
  endtask

  initial begin
    longint tmp [HL];
    int     len;
    for (int i = 0; i < HL; i++) h[i] = 0;
    h[0] = 1;
    len  = 1;
    for (int s = 0; s < NN; s++) begin
      for (int i = 0; i < HL; i++) tmp[i] = 0;
      for (int i = 0; i < len; i++)
        for (int j = 0; j < RR; j++) tmp[i+j] += h[i];
      h = tmp;
      len += RR - 1;
    end

    // Power-up reset held for 75 clocks.
    do_reset(75);

    // DC levels, including the most negative input (full-scale -2^43).
    run_seg("dc_p1", 0,  1, 10 * RR, 1'b1, 1'b1,  64'sd4398046511104);
    run_seg("dc_m1", 0, -1, 10 * RR, 1'b0, 1'b1, -64'sd4398046511104);
    run_seg("dc_m2", 0, -2, 10 * RR, 1'b0, 1'b1, -64'sd8796093022208);

    // Nyquist-rate alternation must be rejected.
    run_seg("alt", 1, 0, 10 * RR, 1'b0, 1'b1, 0);

    // Sigma-delta coded 1 kHz sine, compared word by word with the model.
    run_seg("sine", 2, 0, 10 * RR, 1'b0, 1'b0, 0);

    // Mid-run reset for one clock, then a run identical to power-up.
    run_seg("pre_rst", 0, 1, 300, 1'b0, 1'b0, 0);
    do_reset(1);
    run_seg("post_rst", 0, 1, 10 * RR, 1'b0, 1'b1, 64'sd4398046511104);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
